// File: rtl/ne_seq_cmp_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked inequality checker.
// Optional feature macro used by the top: NE_SEQ_CMP_MISMATCH_IDX_EN.
package ne_seq_cmp_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/ne_seq_cmp_chunk_ne.sv
// chunk_ne: bitwise XOR of two CHUNK-wide slices folded by a balanced OR tree.
// Leaves are padded to a power of two so the tree depth is ceil(log2(CHUNK)).
module chunk_ne #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             ne
);

  localparam int P = (CHUNK > 1) ? (1 << $clog2(CHUNK)) : 1;

  // heap layout: node[0] is the root, leaves start at node[P-1]
  logic [2*P-2:0] node;

  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < CHUNK) begin : g_real
      assign node[P-1+i] = a[i] ^ b[i];
    end else begin : g_pad
      assign node[P-1+i] = 1'b0;
    end
  end

  for (genvar n = 0; n < P - 1; n++) begin : g_tree
    assign node[n] = node[2*n+1] | node[2*n+2];
  end

  assign ne = node[0];

endmodule

// File: rtl/ne_seq_cmp.sv
// ne_seq_cmp: captures an operand pair and scans it CHUNK bits per cycle, LSB first,
// exiting on the first differing chunk. Macro NE_SEQ_CMP_MISMATCH_IDX_EN adds mismatch_idx.
//
// state | meaning
// IDLE  | ready for a new operand pair
// SCAN  | comparing chunk idx of the captured pair
// DONE  | result presented, waiting for out_ready
module ne_seq_cmp
  import ne_seq_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef NE_SEQ_CMP_MISMATCH_IDX_EN
  output logic [$clog2(WIDTH)-1:0] mismatch_idx,
`endif
  output logic             isNotEqual,
  output logic             isEqual
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("ne_seq_cmp: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   reg_a, reg_b;
  logic               ne_q, ne_d;
  logic               load;
  logic [CHUNK-1:0]   chunk_a, chunk_b;
  logic               chunk_diff;
  logic               last;

  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = reg_a[i*CHUNK +: CHUNK];
        chunk_b = reg_b[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_ne #(.CHUNK(CHUNK)) u_chunk_ne (
    .a  (chunk_a),
    .b  (chunk_b),
    .ne (chunk_diff)
  );

  assign last = (idx_q == IDX_W'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ne_d    = ne_q;
    load    = 1'b0;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if (chunk_diff) begin
            ne_d    = 1'b1;
            state_d = DONE;
          end else if (last) begin
            ne_d    = 1'b0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ne_q    <= 1'b0;
      reg_a   <= '0;
      reg_b   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ne_q    <= ne_d;
      if (load) begin
        reg_a <= inA;
        reg_b <= inB;
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign isNotEqual = out_valid & ne_q;
  assign isEqual    = out_valid & ~ne_q;

`ifdef NE_SEQ_CMP_MISMATCH_IDX_EN
  localparam int MI_W = $clog2(WIDTH);

  logic [MI_W-1:0] mi_q, mi_d;
  int              lo_pos;

  // lowest differing bit inside the current chunk, offset by the chunk base
  always_comb begin
    lo_pos = 0;
    for (int j = CHUNK - 1; j >= 0; j--) begin
      if (chunk_a[j] ^ chunk_b[j]) lo_pos = j;
    end
    mi_d = MI_W'(int'(idx_q) * CHUNK + lo_pos);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mi_q <= '0;
    end else if (!flush && state_q == SCAN && chunk_diff) begin
      mi_q <= mi_d;
    end
  end

  assign mismatch_idx = isNotEqual ? mi_q : '0;
`endif

endmodule

// File: tb/tb_ne_seq_cmp.sv
// Directed bench for ne_seq_cmp: vector table for latency/flags plus hand sequences
// for result hold, flush and asynchronous reset.
module tb_ne_seq_cmp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inA, inB;
  logic        out_valid;
  logic        out_ready;
  logic        isNotEqual, isEqual;
`ifdef NE_SEQ_CMP_MISMATCH_IDX_EN
  logic [4:0]  mismatch_idx;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ne_seq_cmp #(.WIDTH(32), .CHUNK(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inA        (inA),
    .inB        (inB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef NE_SEQ_CMP_MISMATCH_IDX_EN
    .mismatch_idx (mismatch_idx),
`endif
    .isNotEqual (isNotEqual),
    .isEqual    (isEqual)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ne;
    int          lat;
    logic [4:0]  mi;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    in_valid = 1'b1;
    inA = a;
    inB = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    inA = $urandom;
    inB = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk({name, " out_valid after hs"}, {31'b0, out_valid}, 32'd0);
    chk({name, " in_ready after hs"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_pair(input string name, input vec_t v);
    int lat;
    accept(v.a, v.b);
    wait_result(lat);
    chk({name, " latency"}, 32'(lat), 32'(v.lat));
    chk({name, " isNotEqual"}, {31'b0, isNotEqual}, {31'b0, v.ne});
    chk({name, " isEqual"}, {31'b0, isEqual}, {31'b0, ~v.ne});
`ifdef NE_SEQ_CMP_MISMATCH_IDX_EN
    chk({name, " mismatch_idx"}, {27'b0, mismatch_idx}, {27'b0, v.mi});
`endif
    handshake(name);
  endtask

  initial begin
    int lat;
    vecs[0] = '{a: 32'hDEADBEEF, b: 32'hDEADBEEF, ne: 1'b0, lat: 8, mi: 5'd0};
    vecs[1] = '{a: 32'h0000_0000, b: 32'h0000_0001, ne: 1'b1, lat: 1, mi: 5'd0};
    vecs[2] = '{a: 32'h0000_0000, b: 32'h8000_0000, ne: 1'b1, lat: 8, mi: 5'd31};
    vecs[3] = '{a: 32'h0000_0000, b: 32'h0000_0F00, ne: 1'b1, lat: 3, mi: 5'd8};
    vecs[4] = '{a: 32'h1234_5678, b: 32'h1234_5658, ne: 1'b1, lat: 2, mi: 5'd5};
    vecs[5] = '{a: 32'h0000_0000, b: 32'h0006_0000, ne: 1'b1, lat: 5, mi: 5'd17};
    vecs[6] = '{a: 32'hFFFF_FFFF, b: 32'h7FFF_FFFF, ne: 1'b1, lat: 8, mi: 5'd31};
    vecs[7] = '{a: 32'h0000_0000, b: 32'h0000_0000, ne: 1'b0, lat: 8, mi: 5'd0};

    reset_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inA = '0;
    inB = '0;
    #12;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset isNotEqual", {31'b0, isNotEqual}, 32'd0);
    chk("reset isEqual", {31'b0, isEqual}, 32'd0);
`ifdef NE_SEQ_CMP_MISMATCH_IDX_EN
    chk("reset mismatch_idx", {27'b0, mismatch_idx}, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_pair($sformatf("vec%0d", i), vecs[i]);
    end

    // result held while the consumer stalls
    accept(32'h0, 32'h1);
    wait_result(lat);
    chk("hold latency", 32'(lat), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      chk("hold out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold isNotEqual", {31'b0, isNotEqual}, 32'd1);
      chk("hold in_ready", {31'b0, in_ready}, 32'd0);
    end
    handshake("hold");

    // flush in IDLE with in_valid must not accept
    @(negedge clock);
    in_valid = 1'b1;
    flush = 1'b1;
    inA = 32'h0;
    inB = 32'h1;
    @(posedge clock);
    #1;
    chk("idle flush in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
    flush = 1'b0;
    @(posedge clock);
    #1;
    chk("idle flush out_valid", {31'b0, out_valid}, 32'd0);

    // flush during SCAN at idx=3
    accept(32'h0, 32'h8000_0000);
    repeat (3) @(posedge clock);
    #1;
    chk("flush pre in_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      chk("flush no pulse", {31'b0, out_valid}, 32'd0);
    end
    run_pair("post flush", vecs[7]);

    // async reset mid-SCAN
    accept(32'h0, 32'h8000_0000);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst scan out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst scan in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("rst scan no pulse", {31'b0, out_valid}, 32'd0);

    // async reset while DONE
    accept(32'h0, 32'h1);
    wait_result(lat);
    chk("rst done latency", 32'(lat), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst done out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst done isNotEqual", {31'b0, isNotEqual}, 32'd0);
    chk("rst done in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    run_pair("post reset", vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
